pwmled_avalon: RTL and testbench

PWMLED_AVALON -- requirements
Module: pwmled_avalon

---
 rtl/pwmled_pkg.sv | 23 ++
 rtl/pwmled_if.sv | 26 ++
 rtl/pwm_core.sv | 115 +++++++++++
 rtl/pwmled_avalon.sv | 88 ++++++++
 tb/tb_pwmled_avalon.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwmled_pkg.sv
// pwmled_pkg -- shared constants for the PWM LED Avalon slave.
//   ADDR_*        : Avalon register word addresses
//   CTRL_*_BIT    : bit positions inside the CTRL register
//   PWM_W_DEFAULT : default counter / period / duty / step width
//   ramp_dir_e    : breathe ramp direction
package pwmled_pkg;

  localparam int unsigned PWM_W_DEFAULT = 16;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_DUTY   = 2'd2;
  localparam logic [1:0] ADDR_STEP   = 2'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_BREATHE_BIT = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } ramp_dir_e;

endpackage

// File: rtl/pwmled_if.sv
// pwmled_if -- Avalon-MM slave bus bundle for pwmled_avalon.
//   avs_address   : register select
//   avs_write     : single-cycle write strobe
//   avs_writedata : write data
//   avs_read      : read strobe
//   avs_readdata  : read data, valid the cycle after avs_read
// Modports: master (bus driver / bench), slave (the PWM block).
interface pwmled_if;

  logic [1:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );

endinterface

// File: rtl/pwm_core.sv
// pwm_core -- period counter, boundary shadow registers, duty comparator
// and breathe ramp for the PWM LED block.
//   clk, reset : clock, synchronous active-high reset
//   i_enable   : run the counter; low holds cnt at 0 and the output low
//   i_breathe  : ramp the active duty by i_step each period
//   i_period   : programmed period (Psh loads it at each boundary)
//   i_duty     : programmed duty (Dact loads it at each boundary in normal mode)
//   i_step     : breathe increment
//   o_pwm      : registered PWM output
// The i_* values are the post-write register values, so a write landing on
// a boundary cycle is applied at that boundary.
module pwm_core
  import pwmled_pkg::*;
#(
  parameter int W = PWM_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_enable,
  input  logic         i_breathe,
  input  logic [W-1:0] i_period,
  input  logic [W-1:0] i_duty,
  input  logic [W-1:0] i_step,
  output logic         o_pwm
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_psh;
  logic [W:0]   r_dact;     // one extra bit: Dact may saturate at Psh+1 = 2^W
  logic         r_run;
  ramp_dir_e    r_dir;
  logic         r_pwm;

  logic [W:0]   w_limit;
  logic [W:0]   w_step_x;
  logic [W:0]   w_sum;
  logic [W:0]   w_dact_ramp;
  ramp_dir_e    w_dir_ramp;
  logic         w_boundary;

  // Ramp arithmetic is W+1 bits so neither the sum nor the ceiling can wrap.
  assign w_limit    = {1'b0, i_period} + (W+1)'(1);
  assign w_step_x   = {1'b0, i_step};
  assign w_sum      = r_dact + w_step_x;
  assign w_boundary = (r_cnt == r_psh);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_dact_ramp = r_dact;
    w_dir_ramp  = r_dir;
    if (i_step != '0) begin
      if (r_dir == DIR_UP) begin
        if (w_sum >= w_limit) begin
          w_dact_ramp = w_limit;
          w_dir_ramp  = DIR_DOWN;
        end else begin
          w_dact_ramp = w_sum;
        end
      end else begin
        if (r_dact <= w_step_x) begin
          w_dact_ramp = '0;
          w_dir_ramp  = DIR_UP;
        end else begin
          w_dact_ramp = r_dact - w_step_x;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_psh  <= '0;
      r_dact <= '0;
      r_run  <= 1'b0;
      r_dir  <= DIR_UP;
      r_pwm  <= 1'b0;
    end else if (!i_enable) begin
      r_cnt <= '0;
      r_run <= 1'b0;
      r_dir <= DIR_UP;
      r_pwm <= 1'b0;
    end else if (!r_run) begin
      // Enable just rose: load the shadows now and start a fresh period.
      r_run  <= 1'b1;
      r_cnt  <= '0;
      r_psh  <= i_period;
      r_dact <= {1'b0, i_duty};
      r_dir  <= DIR_UP;
      r_pwm  <= 1'b0;
    end else begin
      r_pwm <= ({1'b0, r_cnt} < r_dact);
      if (w_boundary) begin
        r_cnt <= '0;
        r_psh <= i_period;
        if (i_breathe) begin
          r_dact <= w_dact_ramp;
          r_dir  <= w_dir_ramp;
        end else begin
          r_dact <= {1'b0, i_duty};
          r_dir  <= DIR_UP;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        // Outside breathe the direction parks at up, so entering breathe
        // always starts the ramp upwards from the current Dact.
        if (!i_breathe) r_dir <= DIR_UP;
      end
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwmled_avalon.sv
// pwmled_avalon -- Avalon-MM PWM LED controller: register file and read mux.
//   clk     : sole clock
//   reset   : synchronous active-high reset
//   avs     : Avalon slave bus (CTRL, PERIOD, DUTY, STEP at addresses 0..3)
//   pwm_out : registered PWM drive to the LED pin
module pwmled_avalon
  import pwmled_pkg::*;
#(
  parameter int W = PWM_W_DEFAULT
) (
  input  logic    clk,
  input  logic    reset,
  pwmled_if.slave avs,
  output logic    pwm_out
);

  logic [1:0]   r_ctrl;
  logic [W-1:0] r_period;
  logic [W-1:0] r_duty;
  logic [W-1:0] r_step;
  logic [31:0]  r_readdata;

  logic [1:0]   w_ctrl_nxt;
  logic [W-1:0] w_period_nxt;
  logic [W-1:0] w_duty_nxt;
  logic [W-1:0] w_step_nxt;
  logic [31:0]  w_rd_mux;
  logic         w_unused_wdata;

  // Post-write values: the core sees a write on the same edge it lands in
  // the register, so a write on a boundary cycle applies at that boundary.
  assign w_ctrl_nxt   = (avs.avs_write && avs.avs_address == ADDR_CTRL)
                        ? avs.avs_writedata[CTRL_BREATHE_BIT:CTRL_EN_BIT] : r_ctrl;
  assign w_period_nxt = (avs.avs_write && avs.avs_address == ADDR_PERIOD)
                        ? avs.avs_writedata[W-1:0] : r_period;
  assign w_duty_nxt   = (avs.avs_write && avs.avs_address == ADDR_DUTY)
                        ? avs.avs_writedata[W-1:0] : r_duty;
  assign w_step_nxt   = (avs.avs_write && avs.avs_address == ADDR_STEP)
                        ? avs.avs_writedata[W-1:0] : r_step;

  // Bits above the register width are ignored on writes.
  assign w_unused_wdata = ^avs.avs_writedata[31:W];

  // Read mux works on the current (pre-write) registers, so a read and write
  // to the same address in one cycle returns the old value.
  always_comb begin
    w_rd_mux = '0;
    case (avs.avs_address)
      ADDR_CTRL:   w_rd_mux[1:0]   = r_ctrl;
      ADDR_PERIOD: w_rd_mux[W-1:0] = r_period;
      ADDR_DUTY:   w_rd_mux[W-1:0] = r_duty;
      ADDR_STEP:   w_rd_mux[W-1:0] = r_step;
      default:     w_rd_mux        = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_period   <= '1;
      r_duty     <= '0;
      r_step     <= '0;
      r_readdata <= '0;
    end else begin
      r_ctrl   <= w_ctrl_nxt;
      r_period <= w_period_nxt;
      r_duty   <= w_duty_nxt;
      r_step   <= w_step_nxt;
      if (avs.avs_read) r_readdata <= w_rd_mux;
    end
  end

  assign avs.avs_readdata = r_readdata;

  pwm_core #(.W(W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (w_ctrl_nxt[CTRL_EN_BIT]),
    .i_breathe (w_ctrl_nxt[CTRL_BREATHE_BIT]),
    .i_period  (w_period_nxt),
    .i_duty    (w_duty_nxt),
    .i_step    (w_step_nxt),
    .o_pwm     (pwm_out)
  );

endmodule

// File: tb/tb_pwmled_avalon.sv
// tb_pwmled_avalon -- self-checking bench for pwmled_avalon.
// A behavioural model (integer arithmetic on the programmed registers) is
// compared against pwm_out and avs_readdata on every falling edge; directed
// scenarios add hand-computed literal expectations on top.
module tb_pwmled_avalon;
  import pwmled_pkg::*;

  localparam int W    = 16;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic pwm_out;
  logic chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  pwmled_if bus ();

  pwmled_avalon #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .avs     (bus),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ctrl, m_period, m_duty, m_step, m_rd;
  int m_cnt, m_psh, m_dact, m_run, m_up, m_pwm;

  always @(posedge clk) begin : model_blk
    int n_ctrl, n_period, n_duty, n_step, wd;
    if (reset) begin
      m_ctrl = 0; m_period = MASK; m_duty = 0; m_step = 0; m_rd = 0;
      m_cnt = 0; m_psh = 0; m_dact = 0; m_run = 0; m_up = 1; m_pwm = 0;
    end else begin
      n_ctrl = m_ctrl; n_period = m_period; n_duty = m_duty; n_step = m_step;
      if (bus.avs_read) begin
        case (bus.avs_address)
          2'd0: m_rd = m_ctrl;
          2'd1: m_rd = m_period;
          2'd2: m_rd = m_duty;
          default: m_rd = m_step;
        endcase
      end
      if (bus.avs_write) begin
        wd = int'(bus.avs_writedata & 32'(MASK));
        case (bus.avs_address)
          2'd0: n_ctrl = int'(bus.avs_writedata & 32'd3);
          2'd1: n_period = wd;
          2'd2: n_duty = wd;
          default: n_step = wd;
        endcase
      end
      if ((n_ctrl & 1) == 0) begin
        m_cnt = 0; m_run = 0; m_pwm = 0; m_up = 1;
      end else if (m_run == 0) begin
        m_run = 1; m_cnt = 0; m_psh = n_period; m_dact = n_duty; m_pwm = 0; m_up = 1;
      end else begin
        m_pwm = (m_cnt < m_dact) ? 1 : 0;
        if (m_cnt == m_psh) begin
          m_cnt = 0;
          m_psh = n_period;
          if ((n_ctrl & 2) == 0) m_dact = n_duty;
          else if (n_step != 0) begin
            if (m_up != 0) begin
              if (m_dact + n_step >= n_period + 1) begin m_dact = n_period + 1; m_up = 0; end
              else m_dact = m_dact + n_step;
            end else begin
              if (m_dact <= n_step) begin m_dact = 0; m_up = 1; end
              else m_dact = m_dact - n_step;
            end
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
        if ((n_ctrl & 2) == 0) m_up = 1;
      end
      m_ctrl = n_ctrl; m_period = n_period; m_duty = n_duty; m_step = n_step;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pwm", 64'(pwm_out), 64'(m_pwm));
      check("model_readdata", 64'(bus.avs_readdata), 64'(m_rd));
    end
  end

  // ---------------- bus helpers (called at a falling edge) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  int h;
  logic [31:0] d;
  int exp_b1 [10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
  int exp_b2 [5]  = '{0, 3, 4, 1, 0};

  initial begin
    reset = 1'b1;
    bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset_pwm", 64'(pwm_out), 64'd0);
    check("reset_readdata", 64'(bus.avs_readdata), 64'd0);
    bus_read(ADDR_PERIOD, d); check("reset_period", 64'(d), 64'hFFFF);

    // PERIOD=9, DUTY=3: 3 high out of 10, first high one cycle after cnt=0
    bus_write(ADDR_PERIOD, 32'd9);
    bus_write(ADDR_DUTY, 32'd3);
    bus_write(ADDR_CTRL, 32'd1);
    check("enable_edge_low", 64'(pwm_out), 64'd0);
    @(negedge clk);
    check("first_high", 64'(pwm_out), 64'd1);
    count_high(9, h); check("p0_highs", 64'(h + 1), 64'd3);
    count_high(10, h); check("p1_highs", 64'(h), 64'd3);
    count_high(10, h); check("p2_highs", 64'(h), 64'd3);

    // DUTY 3->7 written at cnt=5: this period stays 3, next has 7
    h = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) h++;
      if (j == 4) begin
        bus.avs_address = ADDR_DUTY; bus.avs_writedata = 32'd7; bus.avs_write = 1'b1;
      end
      if (j == 5) bus.avs_write = 1'b0;
    end
    check("midwrite_cur_period", 64'(h), 64'd3);
    count_high(10, h); check("midwrite_next_period", 64'(h), 64'd7);

    // DUTY=0 constant low, DUTY=10 constant high
    bus_write(ADDR_CTRL, 32'd0);
    check("disable_low", 64'(pwm_out), 64'd0);
    bus_write(ADDR_DUTY, 32'd0);
    bus_write(ADDR_CTRL, 32'd1);
    count_high(20, h); check("duty0_low", 64'(h), 64'd0);
    bus_write(ADDR_DUTY, 32'd10);
    repeat (12) @(negedge clk);
    count_high(20, h); check("duty10_high", 64'(h), 64'd20);

    // Reset pulsed at cnt=4 in a high phase
    bus_write(ADDR_CTRL, 32'd0);
    bus_write(ADDR_DUTY, 32'd7);
    bus_write(ADDR_CTRL, 32'd1);
    repeat (4) @(negedge clk);
    check("pre_reset_high", 64'(pwm_out), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_forces_low", 64'(pwm_out), 64'd0);
    reset = 1'b0;
    bus.avs_address = ADDR_PERIOD; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    check("rb_period", 64'(bus.avs_readdata), 64'hFFFF);
    bus.avs_address = ADDR_CTRL; bus.avs_read = 1'b1;
    #1 check("rd_latency_hold", 64'(bus.avs_readdata), 64'hFFFF);
    @(negedge clk);
    bus.avs_read = 1'b0;
    check("rb_ctrl", 64'(bus.avs_readdata), 64'd0);
    bus_read(ADDR_DUTY, d); check("rb_duty", 64'(d), 64'd0);
    bus_read(ADDR_STEP, d); check("rb_step", 64'(d), 64'd0);
    count_high(15, h); check("idle_after_reset", 64'(h), 64'd0);

    // Simultaneous read/write returns old value; upper bits ignored
    bus_write(ADDR_DUTY, 32'd5);
    bus.avs_address = ADDR_DUTY; bus.avs_writedata = 32'd9;
    bus.avs_write = 1'b1; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0; bus.avs_read = 1'b0;
    check("rw_same_old", 64'(bus.avs_readdata), 64'd5);
    bus_read(ADDR_DUTY, d); check("rw_same_new", 64'(d), 64'd9);
    bus_write(ADDR_CTRL, 32'hFFFF_FFFC);
    bus_read(ADDR_CTRL, d); check("ctrl_upper_zero", 64'(d), 64'd0);
    bus_write(ADDR_PERIOD, 32'h1234_0005);
    bus_read(ADDR_PERIOD, d); check("period_trunc", 64'(d), 64'd5);

    // Breathe PERIOD=3 STEP=1
    bus_write(ADDR_STEP, 32'd1);
    bus_write(ADDR_PERIOD, 32'd3);
    bus_write(ADDR_DUTY, 32'd0);
    bus_write(ADDR_CTRL, 32'd3);
    for (int k = 0; k < 10; k++) begin
      count_high(4, h); check($sformatf("breathe1_p%0d", k), 64'(h), 64'(exp_b1[k]));
    end

    // Breathe PERIOD=3 STEP=3 (saturation at both ends)
    bus_write(ADDR_CTRL, 32'd0);
    bus_write(ADDR_STEP, 32'd3);
    bus_write(ADDR_CTRL, 32'd3);
    for (int k = 0; k < 5; k++) begin
      count_high(4, h); check($sformatf("breathe3_p%0d", k), 64'(h), 64'(exp_b2[k]));
    end

    // STEP=0 freezes Dact in breathe mode
    bus_write(ADDR_CTRL, 32'd0);
    bus_write(ADDR_DUTY, 32'd2);
    bus_write(ADDR_STEP, 32'd0);
    bus_write(ADDR_CTRL, 32'd3);
    for (int k = 0; k < 3; k++) begin
      count_high(4, h); check($sformatf("step0_p%0d", k), 64'(h), 64'd2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
